seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Multiplexed seven-segment display driver for the parking system's front panel. Consumes the square-wave scan and blink clocks from the frequency divider as plain data signals in the `clk` domain: it synchronises them, edge-detects them, and steps through the display digits one per scan edge. It drives active-low anodes, segments and decimal point, blanks selected digits at the blink rate, and flags a fault if the scan clock stops.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (2..8).
- `WDOG_CYCLES`, default 200_000: `clk` cycles without a scan edge before a fault is declared. One 500 Hz period at 40 MHz is 80_000 cycles.
- `clk`  in  1: system clock, 40 MHz.
- `reset`  in  1: asynchronous, active-low.
- `scan_clk`  in  1: 500 Hz square wave from the divider, treated as asynchronous data.
- `blink_clk`  in  1: 2 Hz square wave from the divider, treated as asynchronous data.
- `digits`  in  4*DIGITS: packed BCD; digit k occupies [4k+3:4k].
- `blink_mask`  in  DIGITS: bit k set means digit k blinks.
- `dp_mask`  in  DIGITS: bit k set means digit k's decimal point is lit.
- `an_n`  out  DIGITS: active-low one-hot anode select.
- `seg_n`  out  7: active-low segments {g,f,e,d,c,b,a}.
- `dp_n`  out  1: active-low decimal point.
- `scan_fault`  out  1: high while the scan clock is considered lost.

## Operation
- Reset values:
  - `an_n` all ones, `seg_n` 7'h7F, `dp_n` 1, `scan_fault` 0.
  - Digit index 0, watchdog count 0.
  - All synchroniser and edge-detect flops 0.
- `scan_clk` and `blink_clk` each pass through a 2-flop synchroniser.
- Scan tick: one-cycle pulse when the synchronised `scan_clk` is 1 and its previous-cycle value was 0. Falling edges produce no tick.
- On a tick:
  - Latch the decoded `digits` nibble at the current index into `seg_n`, plus `dp_n` = ~`dp_mask`[index] and the blink bit `blink_mask`[index].
  - Record the index as the displayed digit.
  - Advance the index, wrapping DIGITS-1 to 0. The first tick after reset therefore shows digit 0.
- `digits`, `blink_mask` and `dp_mask` are sampled only on tick edges.
- Decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Codes 10..15 give 7F (blank).
- `an_n` is registered and recomputed every cycle:
  - All ones if `scan_fault` is set, or if the latched blink bit is 1 and the synchronised `blink_clk` is 1.
  - Otherwise the one-hot-low of the displayed digit.
  - Before the first tick after reset, `an_n` stays all ones.
- Watchdog:
  - The counter clears on a tick and otherwise increments, saturating at WDOG_CYCLES.
  - `scan_fault` is set when the counter reaches WDOG_CYCLES.
  - `scan_fault` clears on the next tick; that tick also updates the display normally.
- Tick and watchdog threshold in the same cycle: the tick wins. The counter clears and `scan_fault` stays 0.
- Reset asserted mid-scan: all state returns to reset values immediately. Scanning restarts at digit 0.

## Timing
- `scan_clk` first sampled high at `clk` edge N:
  - Synchronised value is high after edge N+1.
  - Tick is active during the cycle after N+1.
  - `seg_n`, `dp_n` and the index update at edge N+2.
  - `an_n` updates at edge N+3.
- `blink_clk` change first sampled at edge N reaches `an_n` at edge N+2.
- Watchdog reaching the threshold at edge M sets `scan_fault` at M and forces `an_n` all ones at M+1.
- Scan ticks need at least 3 `clk` cycles of high and of low on `scan_clk`; shorter pulses may be lost.

## Configuration
- `SEG_BLINK_EN` defined:
  - Blink synchroniser and blink gating are present, as described above.
- `SEG_BLINK_EN` undefined:
  - `blink_clk` and `blink_mask` are ignored and no blink flops are built.
  - `an_n` is blanked only by reset (before the first tick) and by `scan_fault`.

## Test plan
- Default parameters, `digits`=16'hF810, masks 0, four scan edges after reset. Required: `seg_n` sequence 40, 79, 00, 7F; `an_n` sequence E, D, B, 7; the fifth edge wraps to E/40.
- `dp_mask`=4'b0010. Required: `dp_n`=0 only while `an_n`=D.
- `SEG_BLINK_EN` defined, `blink_mask`=4'b0001, `blink_clk` high. Required: `an_n`=F while digit 0 is displayed; E when `blink_clk` is low. Undefined: always E.
- `WDOG_CYCLES`=100, `scan_clk` held low after a tick. Required: `scan_fault`=1 and `an_n`=F after 100 cycles; the next scan edge clears the fault and shows the next digit.
- Reset asserted between ticks while digit 2 is displayed. Required: immediately `an_n`=F and `seg_n`=7F; the next tick shows digit 0.
- `scan_clk` high-pulse of 1 cycle. Required: no guaranteed tick. A 3-cycle high pulse produces exactly one tick.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// Front-panel seven-segment bundle: scan/blink inputs, digit data, display outputs.
// The driver owns the slave side; whoever supplies digits owns the master side.
interface seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  scan_clk;
    logic                  blink_clk;
    logic [4*DIGITS-1:0]   digits;
    logic [DIGITS-1:0]     blink_mask;
    logic [DIGITS-1:0]     dp_mask;
    logic [DIGITS-1:0]     an_n;
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic                  scan_fault;

    modport master (
        output scan_clk,
        output blink_clk,
        output digits,
        output blink_mask,
        output dp_mask,
        input  an_n,
        input  seg_n,
        input  dp_n,
        input  scan_fault
    );

    modport slave (
        input  scan_clk,
        input  blink_clk,
        input  digits,
        input  blink_mask,
        input  dp_mask,
        output an_n,
        output seg_n,
        output dp_n,
        output scan_fault
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-seg driver stepping one digit per scan_clk rising edge, with watchdog.
// Define SEG_BLINK_EN to build the blink synchroniser and per-digit blink gating.
module seg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int WDOG_CYCLES = 200_000
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_driver_if.slave  bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(WDOG_CYCLES + 1);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] WLIM = CW'(WDOG_CYCLES);

    logic              scan_s1;
    logic              scan_s2;
    logic              scan_q;
    logic              tick;

    logic [IW-1:0]     idx;
    logic [IW-1:0]     shown;
    logic              shown_v;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;
    logic              fault;
    logic [6:0]        seg_r;
    logic              dp_r;
    logic [DIGITS-1:0] an_r;
    logic [DIGITS-1:0] an_nxt;
    logic [3:0]        nib;
    logic              blank;

    function automatic logic [6:0] dec(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h7F;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_s1 <= 1'b0;
            scan_s2 <= 1'b0;
            scan_q  <= 1'b0;
        end else begin
            scan_s1 <= bus.scan_clk;
            scan_s2 <= scan_s1;
            scan_q  <= scan_s2;
        end
    end

    assign tick = scan_s2 & ~scan_q;
    assign nib  = bus.digits[int'(idx)*4 +: 4];

`ifdef SEG_BLINK_EN
    logic blink_s1;
    logic blink_s2;
    logic blink_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_s1  <= 1'b0;
            blink_s2  <= 1'b0;
            blink_bit <= 1'b0;
        end else begin
            blink_s1 <= bus.blink_clk;
            blink_s2 <= blink_s1;
            if (tick)
                blink_bit <= bus.blink_mask[idx];
        end
    end

    assign blank = blink_bit & blink_s2;
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx     <= '0;
            shown   <= '0;
            shown_v <= 1'b0;
            seg_r   <= 7'h7F;
            dp_r    <= 1'b1;
        end else if (tick) begin
            seg_r   <= dec(nib);
            dp_r    <= ~bus.dp_mask[idx];
            shown   <= idx;
            shown_v <= 1'b1;
            idx     <= (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    // Saturating count; a tick in the threshold cycle clears it and keeps fault low.
    assign cnt_inc = (cnt == WLIM) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            fault <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            fault <= 1'b0;
        end else begin
            cnt <= cnt_inc;
            if (cnt_inc == WLIM)
                fault <= 1'b1;
        end
    end

    always_comb begin
        an_nxt = '1;
        if (!(fault || !shown_v || blank))
            an_nxt[shown] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            an_r <= '1;
        else
            an_r <= an_nxt;
    end

    assign bus.an_n       = an_r;
    assign bus.seg_n      = seg_r;
    assign bus.dp_n       = dp_r;
    assign bus.scan_fault = fault;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: expected display states queued per anode change.
// Blink expectations follow SEG_BLINK_EN as compiled.
module tb_seg_scan_driver;
    localparam int DIGITS = 4;
    localparam int WDOG   = 100;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fault;
    } obs_t;

    logic clk = 1'b0;
    logic reset;

    seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_driver #(
        .DIGITS(DIGITS),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;
    logic [3:0] last_an = 4'hF;

    function automatic obs_t cur();
        obs_t o;
        o.an    = bus.an_n;
        o.seg   = bus.seg_n;
        o.dp    = bus.dp_n;
        o.fault = bus.scan_fault;
        return o;
    endfunction

    task automatic check(input string nm, input obs_t act, input obs_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got an=%h seg=%h dp=%b flt=%b, want an=%h seg=%h dp=%b flt=%b",
                     nm, act.an, act.seg, act.dp, act.fault,
                     req.an, req.seg, req.dp, req.fault);
        end
    endtask

    task automatic expect_ev(input string nm, input logic [3:0] an,
                             input logic [6:0] seg, input logic dp,
                             input logic flt);
        obs_t e;
        e.an = an; e.seg = seg; e.dp = dp; e.fault = flt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: every anode change is one observable display event.
    always @(negedge clk) begin
        if (bus.an_n !== last_an) begin
            last_an = bus.an_n;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected: an=%h seg=%h with no expectation queued",
                         bus.an_n, bus.seg_n);
            end else begin
                check(name_q.pop_front(), cur(), exp_q.pop_front());
            end
        end
    end

    task automatic scan_edge(input int hi, input int lo);
        @(negedge clk);
        bus.scan_clk = 1'b1;
        repeat (hi) @(negedge clk);
        bus.scan_clk = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        obs_t r;
        reset = 1'b0;
        bus.scan_clk   = 1'b0;
        bus.blink_clk  = 1'b0;
        bus.digits     = 16'hF810;
        bus.blink_mask = '0;
        bus.dp_mask    = '0;
        repeat (3) @(negedge clk);
        r.an = 4'hF; r.seg = 7'h7F; r.dp = 1'b1; r.fault = 1'b0;
        check("reset_state", cur(), r);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_tick_blank", cur(), r);

        expect_ev("d0", 4'hE, 7'h40, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("d1", 4'hD, 7'h79, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("d2", 4'hB, 7'h00, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("d3", 4'h7, 7'h7F, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("wrap", 4'hE, 7'h40, 1'b1, 1'b0);
        scan_edge(4, 4);

        bus.dp_mask = 4'b0010;
        expect_ev("dp_d1", 4'hD, 7'h79, 1'b0, 1'b0);
        scan_edge(4, 4);
        expect_ev("dp_d2", 4'hB, 7'h00, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("dp_d3", 4'h7, 7'h7F, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("dp_d0", 4'hE, 7'h40, 1'b1, 1'b0);
        scan_edge(4, 4);
        bus.dp_mask = '0;

        bus.blink_mask = 4'b0001;
        bus.blink_clk  = 1'b1;
        expect_ev("bl_d1", 4'hD, 7'h79, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("bl_d2", 4'hB, 7'h00, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("bl_d3", 4'h7, 7'h7F, 1'b1, 1'b0);
        scan_edge(4, 4);
`ifdef SEG_BLINK_EN
        expect_ev("bl_d0_off", 4'hF, 7'h40, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("bl_low", 4'hE, 7'h40, 1'b1, 1'b0);
        bus.blink_clk = 1'b0;
        repeat (10) @(negedge clk);
        expect_ev("bl_high", 4'hF, 7'h40, 1'b1, 1'b0);
        bus.blink_clk = 1'b1;
        repeat (10) @(negedge clk);
        expect_ev("bl_low2", 4'hE, 7'h40, 1'b1, 1'b0);
        bus.blink_clk = 1'b0;
        repeat (10) @(negedge clk);
`else
        expect_ev("bl_d0_on", 4'hE, 7'h40, 1'b1, 1'b0);
        scan_edge(4, 4);
        bus.blink_clk = 1'b0;
        repeat (10) @(negedge clk);
        bus.blink_clk = 1'b1;
        repeat (10) @(negedge clk);
        bus.blink_clk = 1'b0;
        repeat (10) @(negedge clk);
`endif
        bus.blink_mask = '0;
        expect_ev("bl_d1_after", 4'hD, 7'h79, 1'b1, 1'b0);
        scan_edge(4, 4);

        // Last tick was about 6 cycles ago; fault must still be clear at ~86.
        repeat (80) @(negedge clk);
        total++;
        if (bus.scan_fault !== 1'b0) begin
            bad++;
            $display("FAIL wdog_early: scan_fault=%b want 0", bus.scan_fault);
        end
        expect_ev("wdog_fault", 4'hF, 7'h79, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        total++;
        if (bus.scan_fault !== 1'b1) begin
            bad++;
            $display("FAIL wdog_set: scan_fault=%b want 1", bus.scan_fault);
        end
        expect_ev("wdog_clear", 4'hB, 7'h00, 1'b1, 1'b0);
        scan_edge(4, 4);

        expect_ev("pre_rst_d3", 4'h7, 7'h7F, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("pre_rst_d0", 4'hE, 7'h40, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("pre_rst_d1", 4'hD, 7'h79, 1'b1, 1'b0);
        scan_edge(4, 4);
        expect_ev("pre_rst_d2", 4'hB, 7'h00, 1'b1, 1'b0);
        scan_edge(4, 4);

        expect_ev("mid_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        r.an = 4'hF; r.seg = 7'h7F; r.dp = 1'b1; r.fault = 1'b0;
        check("reset_immediate", cur(), r);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        expect_ev("post_rst_d0", 4'hE, 7'h40, 1'b1, 1'b0);
        scan_edge(4, 4);

        expect_ev("pulse3_d1", 4'hD, 7'h79, 1'b1, 1'b0);
        scan_edge(3, 20);
        r.an = 4'hD; r.seg = 7'h79; r.dp = 1'b1; r.fault = 1'b0;
        check("pulse3_single", cur(), r);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations unmet, next=%s",
                     exp_q.size(), name_q[0]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
